// File: rtl/pifo_access_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pifo_pkg
//   Shared types for the PIFO access path: priority-width helper, the entry
//   record carried between requesters and the PIFO, the last-operation
//   marker used for enqueue/dequeue alternation, and the controller states.
//   No ports; imported by the interface, arbiter and controller.
// ---------------------------------------------------------------------------
package pifo_pkg;

  // Default widths used by the entry record and by the PIFO-side interface.
  localparam int DEF_PRIO_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 8;

  // Number of bits needed to hold priorities 0..max_priority-1.
  function automatic int prio_width(input int max_priority);
    return (max_priority > 1) ? $clog2(max_priority) : 1;
  endfunction

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] data;
    logic [DEF_PRIO_WIDTH-1:0] prio;
  } PifoEntry;

  typedef enum logic {
    ENQ = 1'b0,
    DEQ = 1'b1
  } op_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    CLR      = 2'd1,
    CLR_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/pifo_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// pifo_access_ctrl_if
//   Bundle between the access controller and the single shared PIFO.
//   master: controller side (drives push/pop/clear, sees full/head).
//   slave : PIFO side.
//   Signals:
//     pifo_in_valid / pifo_in_priority / pifo_in : push strobe and entry
//     pifo_in_ready                              : PIFO not full
//     pifo_out_valid / pifo_out_priority / pifo_out : PIFO head
//     pifo_out_ready                             : pop strobe
//     pifo_clear_all                             : flush strobe
// ---------------------------------------------------------------------------
interface pifo_access_ctrl_if #(
  parameter int PRIO_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);

  logic                  pifo_in_valid;
  logic [PRIO_WIDTH-1:0] pifo_in_priority;
  logic [DATA_WIDTH-1:0] pifo_in;
  logic                  pifo_in_ready;
  logic                  pifo_out_valid;
  logic [PRIO_WIDTH-1:0] pifo_out_priority;
  logic [DATA_WIDTH-1:0] pifo_out;
  logic                  pifo_out_ready;
  logic                  pifo_clear_all;

  modport master (
    output pifo_in_valid, pifo_in_priority, pifo_in,
    output pifo_out_ready, pifo_clear_all,
    input  pifo_in_ready,
    input  pifo_out_valid, pifo_out_priority, pifo_out
  );

  modport slave (
    input  pifo_in_valid, pifo_in_priority, pifo_in,
    input  pifo_out_ready, pifo_clear_all,
    output pifo_in_ready,
    output pifo_out_valid, pifo_out_priority, pifo_out
  );

endinterface

// File: rtl/pifo_access_ctrl_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin picker: the winner is the first set bit of
//   req at or above rr_ptr, scanning upward and wrapping.
//   Ports:
//     req     in  NUM_REQ    request vector
//     rr_ptr  in  PTR_WIDTH  highest-priority position this cycle
//     grant   out NUM_REQ    one-hot grant (all zero when no request)
//     winner  out PTR_WIDTH  encoded index of the granted requester
//     any_req out 1          some request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int NUM_REQ   = 4,
  localparam int PTR_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [PTR_WIDTH-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]   grant,
  output logic [PTR_WIDTH-1:0] winner,
  output logic                 any_req
);

  int idx;

  // Walk the requesters starting at rr_ptr; the first hit wins and later
  // hits are ignored via any_req.
  always_comb begin
    grant   = '0;
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!any_req && req[PTR_WIDTH'(idx)]) begin
        any_req                 = 1'b1;
        grant[PTR_WIDTH'(idx)]  = 1'b1;
        winner                  = PTR_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/pifo_access_ctrl.sv
// ---------------------------------------------------------------------------
// pifo_access_ctrl
//   Shares one PIFO between NUM_REQ enqueue requesters and one dequeue
//   client so that at most one push or pop reaches the PIFO per cycle.
//   Enqueuers are arbitrated round-robin; enqueue vs. dequeue alternates on
//   conflict. Also sequences a clear-all and tracks occupancy.
//   Ports:
//     clk, reset         clock, synchronous active-high reset
//     i__enq_valid       per-requester enqueue request
//     i__enq_priority    packed priorities, requester k at [k*PRIO_WIDTH +:]
//     i__enq_data        packed payloads, same packing
//     o__enq_ready       one-hot grant (zero-latency)
//     i__deq_req         level request to pop the head
//     o__deq_valid       one-cycle pulse, the cycle after a pop
//     o__deq_priority    popped priority (registered)
//     o__deq_data        popped payload (registered)
//     i__clear_req       flush request
//     o__clear_busy      high during CLR / CLR_WAIT
//     o__occupancy       entries currently held
//     pifo               master side of the PIFO bundle
// ---------------------------------------------------------------------------
module pifo_access_ctrl
  import pifo_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int NUM_ELEMENTS = 16,
  parameter  int MAX_PRIORITY = 256,
  parameter  int DATA_WIDTH   = 8,
  localparam int PRIO_WIDTH   = prio_width(MAX_PRIORITY),
  localparam int PTR_WIDTH    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int OCC_WIDTH    = $clog2(NUM_ELEMENTS + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            i__enq_valid,
  input  logic [NUM_REQ*PRIO_WIDTH-1:0] i__enq_priority,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i__enq_data,
  output logic [NUM_REQ-1:0]            o__enq_ready,
  input  logic                          i__deq_req,
  output logic                          o__deq_valid,
  output logic [PRIO_WIDTH-1:0]         o__deq_priority,
  output logic [DATA_WIDTH-1:0]         o__deq_data,
  input  logic                          i__clear_req,
  output logic                          o__clear_busy,
  output logic [OCC_WIDTH-1:0]          o__occupancy,
  pifo_access_ctrl_if.master            pifo
);

  localparam logic [OCC_WIDTH-1:0] OCC_FULL = OCC_WIDTH'(NUM_ELEMENTS);
  localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(NUM_REQ - 1);

  state_t                state_q, state_d;
  op_t                   last_op_q;
  logic [PTR_WIDTH-1:0]  rr_ptr_q;
  logic [OCC_WIDTH-1:0]  occ_q;
  logic                  deq_valid_q;
  logic [PRIO_WIDTH-1:0] deq_priority_q;
  logic [DATA_WIDTH-1:0] deq_data_q;

  logic [NUM_REQ-1:0]    arb_grant;
  logic [PTR_WIDTH-1:0]  arb_winner;
  logic                  arb_any;
  logic                  enq_cand;
  logic                  deq_cand;
  logic                  grant_ok;
  logic                  do_enq;
  logic                  do_deq;
  logic [PRIO_WIDTH-1:0] prio_mux;
  logic [DATA_WIDTH-1:0] data_mux;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req     (i__enq_valid),
    .rr_ptr  (rr_ptr_q),
    .grant   (arb_grant),
    .winner  (arb_winner),
    .any_req (arb_any)
  );

  // Select the winning requester's entry for the PIFO push port.
  always_comb begin
    prio_mux = '0;
    data_mux = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (PTR_WIDTH'(k) == arb_winner) begin
        prio_mux = i__enq_priority[k*PRIO_WIDTH +: PRIO_WIDTH];
        data_mux = i__enq_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Decide which single operation (if any) reaches the PIFO this cycle.
  // A clear request seen in RUN suppresses grants in that same cycle, and
  // reset suppresses everything combinationally. On a push/pop tie the
  // operation that did not go last wins.
  always_comb begin
    enq_cand = arb_any && pifo.pifo_in_ready;
    deq_cand = i__deq_req && pifo.pifo_out_valid;
    grant_ok = !reset && (state_q == RUN) && !i__clear_req;
    do_enq   = 1'b0;
    do_deq   = 1'b0;
    if (grant_ok) begin
      if (enq_cand && deq_cand) begin
        if (last_op_q == ENQ) begin
          do_deq = 1'b1;
        end else begin
          do_enq = 1'b1;
        end
      end else if (enq_cand) begin
        do_enq = 1'b1;
      end else if (deq_cand) begin
        do_deq = 1'b1;
      end
    end
  end

  // Clear sequencing: RUN -> CLR (strobe) -> CLR_WAIT (settle) -> RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:      if (i__clear_req) state_d = CLR;
      CLR:      state_d = CLR_WAIT;
      CLR_WAIT: state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // Drive outputs; everything is held low while reset is asserted.
  always_comb begin
    o__enq_ready           = do_enq ? arb_grant : '0;
    pifo.pifo_in_valid     = do_enq;
    pifo.pifo_in_priority  = do_enq ? prio_mux : '0;
    pifo.pifo_in           = do_enq ? data_mux : '0;
    pifo.pifo_out_ready    = do_deq;
    pifo.pifo_clear_all    = !reset && (state_q == CLR);
    o__clear_busy          = !reset && (state_q != RUN);
    o__occupancy           = occ_q;
    o__deq_valid           = deq_valid_q;
    o__deq_priority        = deq_priority_q;
    o__deq_data            = deq_data_q;
  end

  // State, arbitration history, occupancy and the registered pop response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      last_op_q      <= ENQ;
      rr_ptr_q       <= '0;
      occ_q          <= '0;
      deq_valid_q    <= 1'b0;
      deq_priority_q <= '0;
      deq_data_q     <= '0;
    end else begin
      state_q     <= state_d;
      deq_valid_q <= do_deq;

      if (do_enq) begin
        last_op_q <= ENQ;
        rr_ptr_q  <= (arb_winner == PTR_LAST) ? '0 : arb_winner + PTR_WIDTH'(1);
      end else if (do_deq) begin
        last_op_q <= DEQ;
      end

      if (do_deq) begin
        deq_priority_q <= pifo.pifo_out_priority;
        deq_data_q     <= pifo.pifo_out;
      end

      if (state_q == CLR) begin
        occ_q <= '0;
      end else if (do_enq && (occ_q != OCC_FULL)) begin
        occ_q <= occ_q + OCC_WIDTH'(1);
      end else if (do_deq && (occ_q != '0)) begin
        occ_q <= occ_q - OCC_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_pifo_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pifo_access_ctrl
//   Directed bench for pifo_access_ctrl with hand-computed expectations.
//   The bench plays the PIFO itself by driving full/head signals directly.
// ---------------------------------------------------------------------------
module tb_pifo_access_ctrl;
  import pifo_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  enq_valid;
  logic [31:0] enq_priority;
  logic [31:0] enq_data;
  logic [3:0]  enq_ready;
  logic        deq_req;
  logic        deq_valid;
  logic [7:0]  deq_priority;
  logic [7:0]  deq_data;
  logic        clear_req;
  logic        clear_busy;
  logic [4:0]  occupancy;
  PifoEntry    head;

  int vectorCount = 0;
  int missCount   = 0;

  pifo_access_ctrl_if #(.PRIO_WIDTH(8), .DATA_WIDTH(8)) pifo_bus ();

  pifo_access_ctrl #(
    .NUM_REQ      (4),
    .NUM_ELEMENTS (16),
    .MAX_PRIORITY (256),
    .DATA_WIDTH   (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i__enq_valid    (enq_valid),
    .i__enq_priority (enq_priority),
    .i__enq_data     (enq_data),
    .o__enq_ready    (enq_ready),
    .i__deq_req      (deq_req),
    .o__deq_valid    (deq_valid),
    .o__deq_priority (deq_priority),
    .o__deq_data     (deq_data),
    .i__clear_req    (clear_req),
    .o__clear_busy   (clear_busy),
    .o__occupancy    (occupancy),
    .pifo            (pifo_bus)
  );

  always #5 clk = ~clk;

  assign pifo_bus.pifo_out_priority = head.prio;
  assign pifo_bus.pifo_out          = head.data;

  // Structural invariants and occupancy saturation, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      assert ($onehot0(enq_ready)) else $error("[TB] enq_ready not one-hot: %b", enq_ready);
      assert (!(pifo_bus.pifo_in_valid && pifo_bus.pifo_out_ready))
        else $error("[TB] push and pop in the same cycle");
      assert (!(pifo_bus.pifo_out_ready && occupancy == 5'd0))
        else $error("[TB] occupancy underflow saturation");
      assert (!(pifo_bus.pifo_in_valid && occupancy == 5'd16))
        else $error("[TB] occupancy overflow saturation");
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: bench did not complete in time");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Commit the previous cycle at the rising edge, drive this cycle's
  // inputs, then move to the falling edge where outputs are sampled.
  task automatic applyStimulus(input logic rst, input logic [3:0] valid, input logic dreq,
                               input logic clr, input logic in_ready, input logic out_valid,
                               input logic [7:0] hprio, input logic [7:0] hdata);
    @(posedge clk);
    #1;
    reset                  = rst;
    enq_valid              = valid;
    deq_req                = dreq;
    clear_req              = clr;
    pifo_bus.pifo_in_ready = in_ready;
    pifo_bus.pifo_out_valid = out_valid;
    head.prio              = hprio;
    head.data              = hdata;
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] expGrant;
    reset                   = 1'b1;
    enq_valid               = 4'b1111;
    deq_req                 = 1'b0;
    clear_req               = 1'b0;
    pifo_bus.pifo_in_ready  = 1'b1;
    pifo_bus.pifo_out_valid = 1'b0;
    head                    = '0;
    for (int k = 0; k < 4; k++) begin
      enq_priority[k*8 +: 8] = 8'h10 + 8'(k);
      enq_data[k*8 +: 8]     = 8'hA0 + 8'(k);
    end

    // Reset defaults, with requests pending to prove grants are blocked.
    @(negedge clk);
    checkOutput("rst_enq_ready", 32'(enq_ready), 32'h0);
    checkOutput("rst_in_valid", 32'(pifo_bus.pifo_in_valid), 32'h0);
    checkOutput("rst_clear_all", 32'(pifo_bus.pifo_clear_all), 32'h0);
    checkOutput("rst_busy", 32'(clear_busy), 32'h0);
    checkOutput("rst_occ", 32'(occupancy), 32'h0);
    checkOutput("rst_deq_valid", 32'(deq_valid), 32'h0);
    checkOutput("rst_deq_prio", 32'(deq_priority), 32'h0);

    // Round-robin: all four valid, one grant per cycle 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      expGrant = 4'b0001 << (i % 4);
      checkOutput("rr_grant", 32'(enq_ready), 32'(expGrant));
      checkOutput("rr_in_prio", 32'(pifo_bus.pifo_in_priority), 32'h10 + 32'(i % 4));
      checkOutput("rr_in_data", 32'(pifo_bus.pifo_in), 32'hA0 + 32'(i % 4));
      checkOutput("rr_occ", 32'(occupancy), 32'(i));
    end
    applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("full_no_grant", 32'(enq_ready), 32'h0);
    checkOutput("full_in_valid", 32'(pifo_bus.pifo_in_valid), 32'h0);
    checkOutput("full_occ", 32'(occupancy), 32'd5);

    // Mid-stream reset at occupancy 5.
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    checkOutput("midrst_grant", 32'(enq_ready), 32'h0);
    checkOutput("midrst_in_valid", 32'(pifo_bus.pifo_in_valid), 32'h0);
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    checkOutput("midrst_occ", 32'(occupancy), 32'h0);
    checkOutput("midrst_deq_valid", 32'(deq_valid), 32'h0);

    // Build occupancy from requester 2, then alternate with dequeue.
    applyStimulus(1'b0, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    checkOutput("alt_pre0_grant", 32'(enq_ready), 32'b0100);
    applyStimulus(1'b0, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    checkOutput("alt_pre1_grant", 32'(enq_ready), 32'b0100);
    checkOutput("alt_pre1_occ", 32'(occupancy), 32'd1);
    applyStimulus(1'b0, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 8'h55);
    checkOutput("alt1_pop", 32'(pifo_bus.pifo_out_ready), 32'h1);
    checkOutput("alt1_no_enq", 32'(enq_ready), 32'h0);
    checkOutput("alt1_occ", 32'(occupancy), 32'd2);
    applyStimulus(1'b0, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b1, 8'h34, 8'h56);
    checkOutput("alt2_enq", 32'(enq_ready), 32'b0100);
    checkOutput("alt2_no_pop", 32'(pifo_bus.pifo_out_ready), 32'h0);
    checkOutput("alt2_deq_valid", 32'(deq_valid), 32'h1);
    checkOutput("alt2_deq_prio", 32'(deq_priority), 32'h33);
    checkOutput("alt2_deq_data", 32'(deq_data), 32'h55);
    checkOutput("alt2_occ", 32'(occupancy), 32'd1);
    applyStimulus(1'b0, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b1, 8'h34, 8'h56);
    checkOutput("alt3_pop", 32'(pifo_bus.pifo_out_ready), 32'h1);
    checkOutput("alt3_no_enq", 32'(enq_ready), 32'h0);
    checkOutput("alt3_deq_valid", 32'(deq_valid), 32'h0);
    checkOutput("alt3_occ", 32'(occupancy), 32'd2);
    applyStimulus(1'b0, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b1, 8'h34, 8'h56);
    checkOutput("alt4_enq", 32'(enq_ready), 32'b0100);
    checkOutput("alt4_deq_valid", 32'(deq_valid), 32'h1);
    checkOutput("alt4_deq_prio", 32'(deq_priority), 32'h34);
    checkOutput("alt4_deq_data", 32'(deq_data), 32'h56);
    checkOutput("alt4_occ", 32'(occupancy), 32'd1);

    // PIFO full: dequeue served every cycle.
    applyStimulus(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b1, 8'h35, 8'h57);
    checkOutput("gate0_no_enq", 32'(enq_ready), 32'h0);
    checkOutput("gate0_pop", 32'(pifo_bus.pifo_out_ready), 32'h1);
    checkOutput("gate0_occ", 32'(occupancy), 32'd2);
    applyStimulus(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b1, 8'h36, 8'h58);
    checkOutput("gate1_pop", 32'(pifo_bus.pifo_out_ready), 32'h1);
    checkOutput("gate1_deq_prio", 32'(deq_priority), 32'h35);
    checkOutput("gate1_deq_data", 32'(deq_data), 32'h57);
    checkOutput("gate1_occ", 32'(occupancy), 32'd1);
    // PIFO empty: no pop, response pulse drains then stays low.
    applyStimulus(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 8'h36, 8'h58);
    checkOutput("empty0_no_pop", 32'(pifo_bus.pifo_out_ready), 32'h0);
    checkOutput("empty0_deq_valid", 32'(deq_valid), 32'h1);
    checkOutput("empty0_deq_prio", 32'(deq_priority), 32'h36);
    checkOutput("empty0_occ", 32'(occupancy), 32'd0);
    applyStimulus(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 8'h36, 8'h58);
    checkOutput("empty1_no_pop", 32'(pifo_bus.pifo_out_ready), 32'h0);
    checkOutput("empty1_deq_valid", 32'(deq_valid), 32'h0);

    // Clear precedence (rr_ptr is 3, so requester 0 wins the first push).
    applyStimulus(1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    checkOutput("clr_pre_grant", 32'(enq_ready), 32'b0001);
    applyStimulus(1'b0, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b1, 8'h40, 8'h60);
    checkOutput("clr_t_no_enq", 32'(enq_ready), 32'h0);
    checkOutput("clr_t_no_pop", 32'(pifo_bus.pifo_out_ready), 32'h0);
    checkOutput("clr_t_clear_all", 32'(pifo_bus.pifo_clear_all), 32'h0);
    checkOutput("clr_t_busy", 32'(clear_busy), 32'h0);
    checkOutput("clr_t_occ", 32'(occupancy), 32'd1);
    applyStimulus(1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 8'h40, 8'h60);
    checkOutput("clr_t1_no_enq", 32'(enq_ready), 32'h0);
    checkOutput("clr_t1_clear_all", 32'(pifo_bus.pifo_clear_all), 32'h1);
    checkOutput("clr_t1_busy", 32'(clear_busy), 32'h1);
    checkOutput("clr_t1_occ", 32'(occupancy), 32'd1);
    checkOutput("clr_t1_deq_valid", 32'(deq_valid), 32'h0);
    applyStimulus(1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 8'h40, 8'h60);
    checkOutput("clr_t2_no_enq", 32'(enq_ready), 32'h0);
    checkOutput("clr_t2_clear_all", 32'(pifo_bus.pifo_clear_all), 32'h0);
    checkOutput("clr_t2_busy", 32'(clear_busy), 32'h1);
    checkOutput("clr_t2_occ", 32'(occupancy), 32'd0);
    applyStimulus(1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 8'h40, 8'h60);
    checkOutput("clr_t3_grant", 32'(enq_ready), 32'b0001);
    checkOutput("clr_t3_busy", 32'(clear_busy), 32'h0);
    checkOutput("clr_t3_in_prio", 32'(pifo_bus.pifo_in_priority), 32'h10);
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    checkOutput("clr_t4_occ", 32'(occupancy), 32'd1);
    checkOutput("clr_t4_no_enq", 32'(enq_ready), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
